barret_727_rr_sched: RTL and testbench
======================================

Name: barret_727_rr_sched

Overview:
- Round-robin scheduler that shares one pipelined Barrett reduction unit (modulus 727) among NUM_REQ requesters.
- Each requester presents a 19-bit operand over a valid/ready handshake.
- The block grants one requester per cycle, runs the operand through a 2-stage Barrett reduction pipeline, and returns the 10-bit residue tagged with the requester index.
- Sits between the NTT/poly-arithmetic producers and their consumers, replacing per-requester combinational reducers.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of requester tag; must equal ceil(log2(NUM_REQ))
- Q, 727, modulus
- MU, 1442, Barrett constant floor(2^20/Q)
- K, 10, shift amount per Barrett step
- DIN_W, 19, operand width
- DOUT_W, 10, residue width

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- req_valid  input  NUM_REQ  per-requester operand valid
- req_data  input  NUM_REQ*DIN_W  packed operands; requester i at bits [i*DIN_W +: DIN_W]
- req_ready  output  NUM_REQ  per-requester accept, one-hot or zero
- resp_valid  output  1  residue valid
- resp_id  output  ID_W  index of requester whose operand produced resp_data
- resp_data  output  DOUT_W  reduced residue
- resp_ready  input  1  downstream accept

Behaviour:
- Reset: when rst_n=0 at a clock edge, all of the following clear, and every in-flight operand is discarded:
  - s1_valid, s2_valid, resp_valid = 0
  - resp_id = 0, resp_data = 0
  - rr pointer = 0
- Advance enable: adv = !s2_valid || resp_ready. It is combinational, and the whole pipeline moves only when adv=1.
- Arbitration (combinational):
  - When adv=1, grant the first i with req_valid[i]=1, searching from index ptr upward and wrapping modulo NUM_REQ.
  - req_ready[grant]=1; all other req_ready bits are 0.
  - No valid requester, or adv=0: req_ready = 0.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready, and must hold data stable until accepted.
- Pointer: on an accepted transfer, ptr <= (grant+1) mod NUM_REQ. Otherwise ptr holds.
- Stage 1 (register on adv):
  - s1_valid <= accepted transfer.
  - Store din, id = grant, and t = ((din>>K) * MU mod 2^DIN_W) >> K.
- Stage 2 (register on adv):
  - s2_valid <= s1_valid.
  - r = (din - (t*Q mod 2^DIN_W)) mod 2^DIN_W.
  - resp_data <= (r >= Q) ? r-Q : r, truncated to DOUT_W.
  - resp_id <= id.
- Arithmetic: all intermediates are DIN_W bits with wrap-around truncation exactly as written above. Output must be bit-exact to this formula for every 19-bit din, including wrapped cases.
- Outputs: resp_valid = s2_valid.
- Latency and throughput:
  - Accepted at edge n → resp_valid at edge n+2, provided no stall.
  - Sustained throughput is 1 result per cycle with resp_ready held high.
- Backpressure: resp_valid=1 and resp_ready=0 freezes s1, s2 and ptr, holds resp_* stable, and forces req_ready=0. Nothing is dropped or duplicated.
- Bubbles: an empty s1 flows through as a bubble. s2 is overwritten only when adv=1.
- Simultaneous events: an accept and a response handoff in the same cycle are both legal.
- Fairness: a continuously asserting requester waits at most NUM_REQ-1 grants.
- Ordering: responses exit in grant order. There is no reordering across requesters.

Test Plan:
- Reset then single op: requester 0 sends din=1000 → req_ready[0]=1 that cycle; 2 cycles later resp_valid=1, resp_id=0, resp_data=273.
- Boundary values: din=0 → 0; din=727 → 0; din=726 → 726; din=100000 → 401 (q_hat=139874, t=136, r=1128, minus 727). Check all four streamed back-to-back from requester 1 at one result per cycle.
- All four requesters valid continuously, resp_ready=1 → grants 0,1,2,3,0,1… one per cycle; resp_id follows the same sequence 2 cycles later.
- Backpressure: hold resp_ready=0 for 5 cycles with a full pipeline → req_ready=0, resp_valid/resp_id/resp_data stable; after release, remaining results appear in order with no loss or duplicate.
- Reset mid-operation: assert rst_n=0 with s1 and s2 full → next cycle resp_valid=0 and ptr=0; first grant after reset goes to the lowest valid index.
- Random sweep of 10k operands from random requesters with random resp_ready → every response matches the truncated formula and the scoreboard order per requester.

Source files
------------

// File: rtl/barret_727_rr_sched_if.sv
// Request/response bundle for the shared Barrett-727 reducer.
// The master side is the requester and consumer. The slave side is the scheduler.
interface barret_727_rr_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DIN_W   = 19,
  parameter int DOUT_W  = 10
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*DIN_W-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     resp_valid;
  logic [ID_W-1:0]          resp_id;
  logic [DOUT_W-1:0]        resp_data;
  logic                     resp_ready;

  modport master (
    output req_valid, req_data, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data
  );

  modport slave (
    input  req_valid, req_data, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data
  );
endinterface

// File: rtl/barret_727_rr_sched.sv
// Round-robin arbiter that feeds NUM_REQ requesters into one 2-stage Barrett
// reduction pipeline (mod Q). The whole pipeline stalls together on downstream backpressure.
module barret_727_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int Q       = 727,
  parameter int MU      = 1442,
  parameter int K       = 10,
  parameter int DIN_W   = 19,
  parameter int DOUT_W  = 10
) (
  input logic                  clk,
  input logic                  rst_n,
  barret_727_rr_sched_if.slave bus
);

  logic              adv;
  logic              found;
  logic              accept;
  int                idx;
  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   ptr;
  logic [DIN_W-1:0]  sel_din;
  logic [DIN_W-1:0]  q_hat;
  logic [DIN_W-1:0]  t_next;

  logic              s1_valid;
  logic [DIN_W-1:0]  s1_din;
  logic [DIN_W-1:0]  s1_t;
  logic [ID_W-1:0]   s1_id;

  logic              s2_valid;
  logic [ID_W-1:0]   resp_id;
  logic [DOUT_W-1:0] resp_data;

  logic [DIN_W-1:0]  tq;
  logic [DIN_W-1:0]  r;
  logic [DIN_W-1:0]  r_red;

  assign adv = !s2_valid || bus.resp_ready;

  // Scan downward so that the lowest offset from ptr is written last and wins.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (bus.req_valid[idx]) begin
        found = 1'b1;
        grant = ID_W'(idx);
      end
    end
  end

  assign accept = adv && found;

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[grant] = 1'b1;
  end

  // All products are taken at DIN_W width, so they wrap exactly as the reference formula does.
  assign sel_din = bus.req_data[int'(grant)*DIN_W +: DIN_W];
  assign q_hat   = (sel_din >> K) * DIN_W'(MU);
  assign t_next  = q_hat >> K;

  assign tq    = s1_t * DIN_W'(Q);
  assign r     = s1_din - tq;
  assign r_red = (r >= DIN_W'(Q)) ? (r - DIN_W'(Q)) : r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr       <= '0;
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      resp_id   <= '0;
      resp_data <= '0;
    end else if (adv) begin
      s1_valid  <= accept;
      s2_valid  <= s1_valid;
      resp_id   <= s1_id;
      resp_data <= DOUT_W'(r_red);
      if (accept) ptr <= (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
    end
  end

  // Stage-1 payload needs no reset because s1_valid qualifies it.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_din <= sel_din;
      s1_t   <= t_next;
      s1_id  <= grant;
    end
  end

  assign bus.resp_valid = s2_valid;
  assign bus.resp_id    = resp_id;
  assign bus.resp_data  = resp_data;

endmodule

// File: tb/tb_barret_727_rr_sched.sv
// Randomized self-checking bench for barret_727_rr_sched. It checks the DUT against a
// round-robin and two-stage timing model and against per-requester result scoreboards.
module tb_barret_727_rr_sched;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int DIN_W   = 19;
  localparam int DOUT_W  = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  barret_727_rr_sched_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .DIN_W(DIN_W), .DOUT_W(DOUT_W)) bus ();

  barret_727_rr_sched #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .Q(727), .MU(1442), .K(10),
    .DIN_W(DIN_W), .DOUT_W(DOUT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  bit rv[NUM_REQ];
  int rd[NUM_REQ];
  int sb[NUM_REQ][$];

  int  m_ptr;
  bit  m_v[2];
  int  m_id[2];
  int  m_res[2];
  bit  check_en;
  int  issued;
  int  cycles;
  logic [NUM_REQ-1:0] seen_ready;

  int edge_vals[8] = '{0, 1, 726, 727, 728, 1453, 1454, 524287};
  int vals_b[4]    = '{0, 727, 726, 100000};
  int exp_b[4]     = '{0, 0, 726, 401};

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference Barrett step on plain integers, with explicit mod 2^19 wrap-around.
  function automatic int refReduce(input int din);
    int qh, t, r;
    qh = ((din >> 10) * 1442) % (1 << 19);
    t  = qh >> 10;
    r  = din - ((t * 727) % (1 << 19));
    if (r < 0) r += (1 << 19);
    if (r >= 727) r -= 727;
    return r % 1024;
  endfunction

  function automatic int randOperand();
    if ($urandom_range(0, 7) == 0) return edge_vals[$urandom_range(0, 7)];
    return int'($urandom_range(0, 524287));
  endfunction

  task automatic refill();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!rv[i] && $urandom_range(0, 1) == 1) begin
        rv[i] = 1'b1;
        rd[i] = randOperand();
      end
    end
  endtask

  // One clock cycle: drive at negedge, check just after, then advance the model at posedge.
  task automatic applyStimulus(input bit rr, input bit rstn);
    bit adv, acc;
    int g, din, j;
    logic [NUM_REQ-1:0] exp_ready;
    @(negedge clk);
    rst_n = rstn;
    bus.resp_ready = rr;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_valid[i] = rv[i];
      bus.req_data[i*DIN_W +: DIN_W] = DIN_W'(rd[i]);
    end
    #1;
    adv = !m_v[1] || rr;
    acc = 1'b0;
    g   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (m_ptr + k) % NUM_REQ;
      if (!acc && rv[j]) begin
        acc = 1'b1;
        g   = j;
      end
    end
    acc = acc && adv;
    exp_ready = '0;
    if (acc) exp_ready[g] = 1'b1;
    seen_ready = bus.req_ready;
    if (check_en) begin
      checkOutput("req_ready", int'(bus.req_ready), int'(exp_ready));
      checkOutput("resp_valid", int'(bus.resp_valid), int'(m_v[1]));
      if (m_v[1]) begin
        checkOutput("resp_id", int'(bus.resp_id), m_id[1]);
        checkOutput("resp_data", int'(bus.resp_data), m_res[1]);
      end
      if (bus.resp_valid && rr) begin
        checkOutput("sb_nonempty", int'(sb[bus.resp_id].size() > 0), 1);
        if (sb[bus.resp_id].size() > 0) begin
          din = sb[bus.resp_id].pop_front();
          checkOutput("sb_data", int'(bus.resp_data), refReduce(din));
        end
      end
    end
    @(posedge clk);
    if (!rstn) begin
      m_v[0] = 1'b0;
      m_v[1] = 1'b0;
      m_ptr  = 0;
      for (int i = 0; i < NUM_REQ; i++) sb[i].delete();
      if (acc) rv[g] = 1'b0;
    end else if (adv) begin
      m_v[1]   = m_v[0];
      m_id[1]  = m_id[0];
      m_res[1] = m_res[0];
      m_v[0]   = acc;
      m_id[0]  = g;
      m_res[0] = refReduce(rd[g]);
      if (acc) begin
        sb[g].push_back(rd[g]);
        rv[g] = 1'b0;
        m_ptr = (g + 1) % NUM_REQ;
        issued++;
      end
    end
  endtask

  function automatic bit anyPending();
    bit p;
    p = m_v[0] || m_v[1];
    for (int i = 0; i < NUM_REQ; i++) p = p || rv[i];
    return p;
  endfunction

  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rv[i] = 1'b0;
      rd[i] = 0;
    end
    m_ptr = 0; m_v[0] = 1'b0; m_v[1] = 1'b0;
    m_id[0] = 0; m_id[1] = 0; m_res[0] = 0; m_res[1] = 0;
    check_en = 1'b0;
    issued   = 0;

    applyStimulus(1'b1, 1'b0);
    check_en = 1'b1;
    applyStimulus(1'b1, 1'b0);
    #2;
    checkOutput("rst_resp_valid", int'(bus.resp_valid), 0);
    checkOutput("rst_resp_id", int'(bus.resp_id), 0);
    checkOutput("rst_resp_data", int'(bus.resp_data), 0);

    $display("[TB] single operation");
    rv[0] = 1'b1; rd[0] = 1000;
    applyStimulus(1'b1, 1'b1);
    checkOutput("t1_ready", int'(seen_ready), 1);
    applyStimulus(1'b1, 1'b1);
    #2;
    checkOutput("t1_resp_valid", int'(bus.resp_valid), 1);
    checkOutput("t1_resp_id", int'(bus.resp_id), 0);
    checkOutput("t1_resp_data", int'(bus.resp_data), 273);

    $display("[TB] boundary values back-to-back");
    for (int j = 0; j < 5; j++) begin
      if (j < 4) begin
        rv[1] = 1'b1;
        rd[1] = vals_b[j];
      end
      applyStimulus(1'b1, 1'b1);
      if (j < 4) checkOutput("t2_ready", int'(seen_ready), 2);
      if (j >= 1) begin
        #2;
        checkOutput("t2_resp_valid", int'(bus.resp_valid), 1);
        checkOutput("t2_resp_id", int'(bus.resp_id), 1);
        checkOutput("t2_resp_data", int'(bus.resp_data), exp_b[j-1]);
      end
    end

    $display("[TB] all requesters continuous");
    applyStimulus(1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!rv[i]) begin
          rv[i] = 1'b1;
          rd[i] = randOperand();
        end
      end
      applyStimulus(1'b1, 1'b1);
      checkOutput("t3_grant", int'(seen_ready), 1 << (k % 4));
      if (k >= 1) begin
        #2;
        checkOutput("t3_resp_id", int'(bus.resp_id), (k - 1) % 4);
      end
    end

    $display("[TB] backpressure");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput("t4_ready", int'(seen_ready), 0);
      #2;
      checkOutput("t4_hold_valid", int'(bus.resp_valid), 1);
      checkOutput("t4_hold_id", int'(bus.resp_id), 2);
    end
    for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b1);

    $display("[TB] reset mid-operation");
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        rv[i] = 1'b1;
        rd[i] = randOperand();
      end
      applyStimulus(1'b1, 1'b1);
    end
    applyStimulus(1'b1, 1'b0);
    #2;
    checkOutput("t5_resp_valid", int'(bus.resp_valid), 0);
    checkOutput("t5_resp_id", int'(bus.resp_id), 0);
    checkOutput("t5_resp_data", int'(bus.resp_data), 0);
    for (int i = 0; i < NUM_REQ; i++) rv[i] = 1'b0;
    rv[1] = 1'b1; rd[1] = randOperand();
    rv[3] = 1'b1; rd[3] = randOperand();
    applyStimulus(1'b1, 1'b1);
    checkOutput("t5_first_grant", int'(seen_ready), 2);

    $display("[TB] random sweep");
    issued = 0;
    cycles = 0;
    while (issued < 10000 && cycles < 60000) begin
      refill();
      applyStimulus($urandom_range(0, 3) != 0, 1'b1);
      cycles++;
    end
    checkOutput("sweep_issued", int'(issued >= 10000), 1);

    cycles = 0;
    while (anyPending() && cycles < 200) begin
      applyStimulus(1'b1, 1'b1);
      cycles++;
    end
    applyStimulus(1'b1, 1'b1);
    checkOutput("drain_sb_empty",
                sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size(), 0);
    #2;
    checkOutput("drain_resp_valid", int'(bus.resp_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
